riscv_issue_ctl: RTL and testbench
==================================

# riscv_issue_ctl

In-order issue controller between the decode stage and the execute units. It holds one decoded instruction and tracks pending register writes in a scoreboard. It issues the instruction only when its source and destination registers are free, the in-flight limit is not reached and execute is ready. It back-pressures decode while stalled.

## Interface
Parameters:
- MAX_INFLIGHT, 4: maximum issued instructions with pending register writeback (1..15).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- idu_vld  in  1  decoded instruction valid.
- idu_addr  in  32  instruction address.
- idu_data  in  riscv_pkg::instr_type  32-bit instruction, compressed forms already expanded.
- idu_rdy  out  1  controller accepts idu_data this cycle.
- iss_vld  out  1  instruction presented to execute.
- iss_addr  out  32  held address.
- iss_data  out  riscv_pkg::instr_type  held instruction.
- iss_rdy  in  1  execute accepts this cycle.
- wb_vld  in  1  register writeback completes.
- wb_rd  in  5  writeback destination.
- flush  in  1  discard held instruction (redirect).
- busy_o  out  32  scoreboard bits, for debug and verification.

## Operation
- Accept when idu_vld && idu_rdy.
- idu_rdy = !hold_vld || issue_fire.
- Field extraction: rd = [11:7], rs1 = [19:15], rs2 = [24:20], opcode = [6:0].
- uses_rs1: every opcode except LUI, AUIPC and JAL.
- uses_rs2: OP, BRANCH and STORE.
- writes_rd: every opcode except BRANCH, STORE, MISC-MEM and SYSTEM, and only when rd != 0.
- hazard = (uses_rs1 && busy[rs1]) || (uses_rs2 && busy[rs2]) || (writes_rd && busy[rd]) || (writes_rd && cnt == MAX_INFLIGHT).
- iss_vld = hold_vld && !hazard.
- issue_fire = iss_vld && iss_rdy.
- FSM states and transitions:
  - EMPTY to HELD on accept.
  - HELD to EMPTY on issue_fire without a new accept.
  - HELD stays HELD on issue_fire plus accept (back-to-back).
  - HELD stays HELD on hazard or !iss_rdy.
  - Any state to EMPTY on flush.
- Flush has priority over accept and issue in the same cycle: nothing issues, nothing is accepted.
- Flush does not touch the scoreboard or cnt; in-flight instructions still write back.
- Scoreboard behaviour:
  - issue_fire with writes_rd sets busy[rd].
  - wb_vld clears busy[wb_rd].
  - busy[0] is hardwired 0.
  - wb_vld for a non-busy register is ignored for busy, but still decrements cnt if cnt > 0.
- cnt is a 4-bit counter:
  - +1 on issue_fire && writes_rd.
  - -1 on wb_vld.
  - Both in the same cycle: cnt unchanged.
  - Saturates at 0 and at MAX_INFLIGHT.

## Timing
- Reset values: hold_vld=0, iss_vld=0, busy=0, cnt=0, idu_rdy=1, iss_addr/iss_data=0.
- Latency: accept in cycle N, iss_vld earliest in N+1.
- Steady state: one issue per cycle with no hazards.
- iss_vld, iss_addr and iss_data stay stable while iss_vld && !iss_rdy.
- iss_vld can fall without a handshake only on flush.
- idu_rdy depends combinationally on iss_rdy.
- A writeback clears its busy bit at the clock edge, so a dependent instruction issues one cycle after wb_vld.
- Reset mid-operation discards the held instruction and clears all state in one cycle.

## Configuration
- RISCV_ISSUE_WB_BYPASS_EN defined:
  - The hazard check uses busy & ~(wb_vld << wb_rd), and the cnt limit check uses cnt − wb_vld.
  - A dependent instruction issues in the same cycle as its writeback.
- Undefined: the one-cycle penalty described above applies.

## Structure
- riscv_pkg gains:
  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, MISC_MEM, SYSTEM).
  - Functions uses_rs1, uses_rs2 and writes_rd over instr_type.
- Sub-module riscv_scoreboard:
  - Holds the busy vector and cnt.
  - Inputs: set enable and index, clear enable and index, and the held instruction's register indices.
  - Outputs: the hazard terms.
- riscv_issue_ctl contains the holding register, FSM and handshake logic.

## Test plan
- Independent stream: ADDI x1, ADDI x2, ADDI x3 with iss_rdy=1 → issued in cycles 1, 2, 3; idu_rdy stays 1.
- RAW hazard: ADDI x5 issues, then ADD x6,x5,x5 is held; wb_vld with wb_rd=5 in cycle 4 → ADD issues in cycle 5 (cycle 4 with the bypass macro); busy_o bit 5 set, then cleared.
- Backpressure: iss_rdy=0 for 3 cycles with idu_vld=1 → iss_data stable, idu_rdy=0, no accept; one accept on the cycle iss_rdy returns.
- Limit: MAX_INFLIGHT=4, four independent writers with no wb → fifth held with iss_vld=0; one wb → fifth issues the next cycle.
- Flush while held and stalled on x7 → iss_vld=0 the next cycle; busy_o bit 7 unchanged; cnt unchanged.
- Reset asserted with hold_vld=1, busy=0x0000_00A0 and cnt=2 → all zero and idu_rdy=1 the next cycle; writes to x0 never set busy.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: instruction type, opcodes and register-usage decode for the issue controller.
package riscv_pkg;
  typedef logic [31:0] instr_type;
  typedef enum logic {EMPTY, HELD} issue_state_t;
  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] MISC_MEM = 7'b0001111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;
  function automatic logic [4:0] rd_of(instr_type i);
    return i[11:7];
  endfunction
  function automatic logic [4:0] rs1_of(instr_type i);
    return i[19:15];
  endfunction
  function automatic logic [4:0] rs2_of(instr_type i);
    return i[24:20];
  endfunction
  function automatic logic uses_rs1(instr_type i);
    return !(i[6:0] inside {LUI, AUIPC, JAL});
  endfunction
  function automatic logic uses_rs2(instr_type i);
    return i[6:0] inside {OP, BRANCH, STORE};
  endfunction
  function automatic logic writes_rd(instr_type i);
    return !(i[6:0] inside {BRANCH, STORE, MISC_MEM, SYSTEM}) && i[11:7] != 5'd0;
  endfunction
endpackage

// File: rtl/riscv_scoreboard.sv
// riscv_scoreboard: pending-writeback busy vector and in-flight counter with hazard lookups.
// RISCV_ISSUE_WB_BYPASS_EN lets a same-cycle writeback hide its busy bit and count from the checks.
module riscv_scoreboard #(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        set_en,
  input  logic [4:0]  set_idx,
  input  logic        clr_en,
  input  logic [4:0]  clr_idx,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  output logic        busy_rs1,
  output logic        busy_rs2,
  output logic        busy_rd,
  output logic        full,
  output logic [31:0] busy
);
  logic [3:0]  cnt;
  logic [31:0] busy_chk;
  logic [3:0]  cnt_chk;
`ifdef RISCV_ISSUE_WB_BYPASS_EN
  assign busy_chk = busy & ~(32'(clr_en) << clr_idx);
  assign cnt_chk  = cnt - 4'(clr_en && cnt != 4'd0);
`else
  assign busy_chk = busy;
  assign cnt_chk  = cnt;
`endif
  assign busy_rs1 = busy_chk[rs1];
  assign busy_rs2 = busy_chk[rs2];
  assign busy_rd  = busy_chk[rd];
  assign full     = cnt_chk == 4'(MAX_INFLIGHT);
  // set after clear so a same-cycle wb and reissue of one register leaves it pending
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      busy <= '0;
      cnt  <= '0;
    end else begin
      busy <= ((busy & ~(32'(clr_en) << clr_idx)) | (32'(set_en) << set_idx)) & ~32'd1;
      cnt  <= (set_en && !clr_en && cnt != 4'(MAX_INFLIGHT)) ? cnt + 4'd1 :
              (!set_en && clr_en && cnt != 4'd0) ? cnt - 4'd1 : cnt;
    end
  end
endmodule

// File: rtl/riscv_issue_ctl.sv
// riscv_issue_ctl: in-order single-entry issue stage with scoreboard-based hazard stall.
// Define RISCV_ISSUE_WB_BYPASS_EN to issue dependents in the same cycle as their writeback.
module riscv_issue_ctl
  import riscv_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        idu_vld,
  input  logic [31:0] idu_addr,
  input  instr_type   idu_data,
  output logic        idu_rdy,
  output logic        iss_vld,
  output logic [31:0] iss_addr,
  output instr_type   iss_data,
  input  logic        iss_rdy,
  input  logic        wb_vld,
  input  logic [4:0]  wb_rd,
  input  logic        flush,
  output logic [31:0] busy_o
);
  issue_state_t state;
  logic [31:0]  hold_addr;
  instr_type    hold_data;
  logic hold_vld, wr, hazard, issue_fire, accept;
  logic busy_rs1, busy_rs2, busy_rd, full;
  assign hold_vld   = state == HELD;
  assign wr         = writes_rd(hold_data);
  assign hazard     = (uses_rs1(hold_data) && busy_rs1) || (uses_rs2(hold_data) && busy_rs2) ||
                      (wr && (busy_rd || full));
  // flush outranks the handshake so execute never sees a discarded instruction fire
  assign iss_vld    = hold_vld && !hazard && !flush;
  assign issue_fire = iss_vld && iss_rdy;
  assign idu_rdy    = !flush && (!hold_vld || issue_fire);
  assign accept     = idu_vld && idu_rdy;
  assign iss_addr   = hold_addr;
  assign iss_data   = hold_data;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= EMPTY;
      hold_addr <= '0;
      hold_data <= '0;
    end else begin
      state <= flush ? EMPTY : accept ? HELD : issue_fire ? EMPTY : state;
      if (accept) begin
        hold_addr <= idu_addr;
        hold_data <= idu_data;
      end
    end
  end
  riscv_scoreboard #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_sb (
    .clock    (clock),
    .reset_n  (reset_n),
    .set_en   (issue_fire && wr),
    .set_idx  (rd_of(hold_data)),
    .clr_en   (wb_vld),
    .clr_idx  (wb_rd),
    .rs1      (rs1_of(hold_data)),
    .rs2      (rs2_of(hold_data)),
    .rd       (rd_of(hold_data)),
    .busy_rs1 (busy_rs1),
    .busy_rs2 (busy_rs2),
    .busy_rd  (busy_rd),
    .full     (full),
    .busy     (busy_o)
  );
endmodule

// File: tb/tb_riscv_issue_ctl.sv
// tb_riscv_issue_ctl: directed scenarios plus randomized traffic against a behavioural model.
module tb_riscv_issue_ctl;
  import riscv_pkg::*;
  localparam int MAXI = 4;
`ifdef RISCV_ISSUE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [6:0] OPS [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h0f, 7'h73};
  logic clock = 1'b0, reset_n = 1'b0, idu_vld = 1'b0, iss_rdy = 1'b0, wb_vld = 1'b0, flush = 1'b0;
  logic [31:0] idu_addr = '0, iss_addr, busy_o;
  instr_type idu_data = '0, iss_data;
  logic [4:0] wb_rd = '0;
  logic idu_rdy, iss_vld;
  int tests = 0, fails = 0;
  logic [31:0] pc = 32'h1000;
  bit m_hv;
  logic [31:0] m_addr, m_data;
  bit [31:0] m_busy;
  int m_cnt;

  always #5 clock = ~clock;

  riscv_issue_ctl #(.MAX_INFLIGHT(MAXI)) dut (
    .clock(clock), .reset_n(reset_n), .idu_vld(idu_vld), .idu_addr(idu_addr), .idu_data(idu_data),
    .idu_rdy(idu_rdy), .iss_vld(iss_vld), .iss_addr(iss_addr), .iss_data(iss_data), .iss_rdy(iss_rdy),
    .wb_vld(wb_vld), .wb_rd(wb_rd), .flush(flush), .busy_o(busy_o)
  );

  function automatic logic [31:0] addi(int rd, int rs1);
    return {12'd1, 5'(rs1), 3'b000, 5'(rd), 7'h13};
  endfunction
  function automatic logic [31:0] add(int rd, int rs1, int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] rnd_instr();
    logic [31:0] d;
    d = $urandom;
    d[6:0] = OPS[$urandom_range(0, 10)];
    d[11:7] = 5'($urandom_range(0, 7));
    d[19:15] = 5'($urandom_range(0, 7));
    d[24:20] = 5'($urandom_range(0, 7));
    return d;
  endfunction

  // Reference rules: which registers an instruction reads and writes, by opcode.
  function automatic bit m_reads1(logic [31:0] d);
    return !(d[6:0] inside {7'h37, 7'h17, 7'h6f});
  endfunction
  function automatic bit m_reads2(logic [31:0] d);
    return d[6:0] inside {7'h33, 7'h63, 7'h23};
  endfunction
  function automatic bit m_writes(logic [31:0] d);
    return !(d[6:0] inside {7'h63, 7'h23, 7'h0f, 7'h73}) && d[11:7] != 5'd0;
  endfunction
  function automatic bit m_hazard();
    bit [31:0] b;
    int c;
    b = m_busy;
    c = m_cnt;
    if (BYP && wb_vld) begin
      b[wb_rd] = 1'b0;
      if (c > 0) c--;
    end
    return (m_reads1(m_data) && b[m_data[19:15]]) || (m_reads2(m_data) && b[m_data[24:20]]) ||
           (m_writes(m_data) && (b[m_data[11:7]] || c == MAXI));
  endfunction
  function automatic bit exp_iss();
    return m_hv && !m_hazard() && !flush;
  endfunction
  function automatic bit exp_rdy();
    return !flush && (!m_hv || (exp_iss() && iss_rdy));
  endfunction

  task automatic tick();
    bit fire, acc, wr;
    bit [31:0] nb;
    int nc;
    fire = exp_iss() && iss_rdy;
    acc = idu_vld && exp_rdy();
    wr = fire && m_writes(m_data);
    nb = m_busy;
    if (wb_vld) nb[wb_rd] = 1'b0;
    if (wr) nb[m_data[11:7]] = 1'b1;
    nb[0] = 1'b0;
    nc = m_cnt + int'(wr) - int'(wb_vld);
    nc = nc < 0 ? 0 : nc > MAXI ? MAXI : nc;
    @(posedge clock);
    if (!reset_n) begin
      m_hv = 0; m_addr = '0; m_data = '0; m_busy = '0; m_cnt = 0;
    end else begin
      m_busy = nb;
      m_cnt = nc;
      if (flush) m_hv = 0;
      else if (acc) begin m_hv = 1; m_addr = idu_addr; m_data = idu_data; end
      else if (fire) m_hv = 0;
    end
    #1;
  endtask

  task automatic drive(bit v, logic [31:0] d, bit rdy, bit wb, logic [4:0] r, bit fl);
    idu_vld = v; idu_data = d; idu_addr = pc; pc += 4;
    iss_rdy = rdy; wb_vld = wb; wb_rd = r; flush = fl;
    #1;
  endtask

  task automatic do_reset();
    drive(0, '0, 0, 0, '0, 0);
    reset_n = 0;
    tick(); tick();
    reset_n = 1;
  endtask

  task automatic test_reset();
    reset_n = 0;
    drive(0, '0, 0, 0, '0, 0);
    tick();
    drive(0, '0, 0, 0, '0, 0);
    tests++; if (iss_vld !== 1'b0) begin fails++; $display("FAIL reset_iss_vld got %0b want 0", iss_vld); end
    tests++; if (idu_rdy !== 1'b1) begin fails++; $display("FAIL reset_idu_rdy got %0b want 1", idu_rdy); end
    tests++; if (busy_o !== 32'd0) begin fails++; $display("FAIL reset_busy got %h want 0", busy_o); end
    tests++; if (iss_data !== 32'd0 || iss_addr !== 32'd0) begin fails++; $display("FAIL reset_hold got %h/%h want 0/0", iss_addr, iss_data); end
    reset_n = 1;
  endtask

  task automatic test_independent();
    do_reset();
    drive(1, addi(1, 0), 1, 0, '0, 0);
    tests++; if (idu_rdy !== 1'b1) begin fails++; $display("FAIL indep_rdy0 got %0b want 1", idu_rdy); end
    tick();
    for (int i = 2; i <= 4; i++) begin
      drive(i <= 3, addi(i, 0), 1, 0, '0, 0);
      tests++; if (iss_vld !== 1'b1 || iss_data !== addi(i - 1, 0)) begin fails++; $display("FAIL indep_issue%0d got %0b/%h want 1/%h", i - 1, iss_vld, iss_data, addi(i - 1, 0)); end
      tests++; if (idu_rdy !== 1'b1) begin fails++; $display("FAIL indep_rdy%0d got %0b want 1", i - 1, idu_rdy); end
      tick();
    end
    tests++; if (busy_o !== 32'h0000_000E) begin fails++; $display("FAIL indep_busy got %h want 0000000e", busy_o); end
    for (int i = 1; i <= 3; i++) begin drive(0, '0, 1, 1, 5'(i), 0); tick(); end
    tests++; if (busy_o !== 32'd0) begin fails++; $display("FAIL indep_drain got %h want 0", busy_o); end
  endtask

  task automatic test_raw();
    do_reset();
    drive(1, addi(5, 0), 1, 0, '0, 0); tick();
    drive(1, add(6, 5, 5), 1, 0, '0, 0);
    tests++; if (iss_vld !== 1'b1 || iss_data !== addi(5, 0)) begin fails++; $display("FAIL raw_first got %0b/%h want 1/%h", iss_vld, iss_data, addi(5, 0)); end
    tick();
    drive(0, '0, 1, 0, '0, 0);
    tests++; if (iss_vld !== 1'b0 || busy_o[5] !== 1'b1) begin fails++; $display("FAIL raw_stall got vld=%0b busy5=%0b want 0/1", iss_vld, busy_o[5]); end
    tick();
    drive(0, '0, 1, 0, '0, 0);
    tests++; if (iss_vld !== 1'b0) begin fails++; $display("FAIL raw_stall2 got %0b want 0", iss_vld); end
    tick();
    drive(0, '0, 1, 1, 5'd5, 0);
    tests++; if (iss_vld !== BYP) begin fails++; $display("FAIL raw_wb_cycle got %0b want %0b", iss_vld, BYP); end
    tick();
`ifndef RISCV_ISSUE_WB_BYPASS_EN
    drive(0, '0, 1, 0, '0, 0);
    tests++; if (iss_vld !== 1'b1 || iss_data !== add(6, 5, 5) || busy_o[5] !== 1'b0) begin fails++; $display("FAIL raw_after_wb got vld=%0b data=%h busy5=%0b want 1/%h/0", iss_vld, iss_data, busy_o[5], add(6, 5, 5)); end
    tick();
`endif
    tests++; if (busy_o !== 32'h0000_0040) begin fails++; $display("FAIL raw_busy_end got %h want 00000040", busy_o); end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(1, addi(1, 0), 0, 0, '0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, addi(2, 0), 0, 0, '0, 0);
      tests++; if (iss_vld !== 1'b1 || iss_data !== addi(1, 0) || idu_rdy !== 1'b0) begin fails++; $display("FAIL bp_hold%0d got vld=%0b data=%h rdy=%0b want 1/%h/0", i, iss_vld, iss_data, idu_rdy, addi(1, 0)); end
      tick();
    end
    drive(1, addi(2, 0), 1, 0, '0, 0);
    tests++; if (idu_rdy !== 1'b1) begin fails++; $display("FAIL bp_release_rdy got %0b want 1", idu_rdy); end
    tick();
    drive(0, '0, 1, 0, '0, 0);
    tests++; if (iss_vld !== 1'b1 || iss_data !== addi(2, 0)) begin fails++; $display("FAIL bp_next got %0b/%h want 1/%h", iss_vld, iss_data, addi(2, 0)); end
    tick();
  endtask

  task automatic test_limit();
    do_reset();
    for (int i = 1; i <= 4; i++) begin drive(1, addi(i, 0), 1, 0, '0, 0); tick(); end
    drive(1, addi(8, 0), 1, 0, '0, 0);
    tests++; if (iss_vld !== 1'b1 || iss_data !== addi(4, 0)) begin fails++; $display("FAIL limit_fourth got %0b/%h want 1/%h", iss_vld, iss_data, addi(4, 0)); end
    tick();
    drive(0, '0, 1, 0, '0, 0);
    tests++; if (iss_vld !== 1'b0) begin fails++; $display("FAIL limit_fifth_held got %0b want 0", iss_vld); end
    tick();
    drive(0, '0, 1, 1, 5'd1, 0);
    tests++; if (iss_vld !== BYP) begin fails++; $display("FAIL limit_wb_cycle got %0b want %0b", iss_vld, BYP); end
    tick();
`ifndef RISCV_ISSUE_WB_BYPASS_EN
    drive(0, '0, 1, 0, '0, 0);
    tests++; if (iss_vld !== 1'b1 || iss_data !== addi(8, 0)) begin fails++; $display("FAIL limit_fifth_issue got %0b/%h want 1/%h", iss_vld, iss_data, addi(8, 0)); end
    tick();
`endif
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, addi(7, 0), 1, 0, '0, 0); tick();
    drive(1, add(9, 7, 0), 1, 0, '0, 0); tick();
    drive(0, '0, 1, 0, '0, 0);
    tests++; if (iss_vld !== 1'b0 || busy_o !== 32'h80) begin fails++; $display("FAIL flush_pre got vld=%0b busy=%h want 0/00000080", iss_vld, busy_o); end
    tick();
    drive(1, addi(3, 0), 1, 0, '0, 1); tick();
    drive(0, '0, 1, 0, '0, 0);
    tests++; if (iss_vld !== 1'b0 || busy_o !== 32'h80 || idu_rdy !== 1'b1) begin fails++; $display("FAIL flush_post got vld=%0b busy=%h rdy=%0b want 0/00000080/1", iss_vld, busy_o, idu_rdy); end
    tick();
    for (int i = 1; i <= 4; i++) begin drive(1, addi(i, 0), 1, 0, '0, 0); tick(); end
    drive(0, '0, 1, 0, '0, 0);
    tests++; if (iss_vld !== 1'b0 || busy_o !== 32'h8E) begin fails++; $display("FAIL flush_cnt_kept got vld=%0b busy=%h want 0/0000008e", iss_vld, busy_o); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1, addi(5, 0), 1, 0, '0, 0); tick();
    drive(1, addi(7, 0), 1, 0, '0, 0); tick();
    drive(1, add(9, 5, 5), 1, 0, '0, 0); tick();
    drive(0, '0, 1, 0, '0, 0);
    tests++; if (busy_o !== 32'hA0 || iss_vld !== 1'b0) begin fails++; $display("FAIL rmid_pre got busy=%h vld=%0b want 000000a0/0", busy_o, iss_vld); end
    reset_n = 0; tick(); reset_n = 1;
    drive(0, '0, 1, 0, '0, 0);
    tests++; if (iss_vld !== 1'b0 || busy_o !== 32'd0 || idu_rdy !== 1'b1 || iss_data !== 32'd0) begin fails++; $display("FAIL rmid_post got vld=%0b busy=%h rdy=%0b data=%h want 0/0/1/0", iss_vld, busy_o, idu_rdy, iss_data); end
    for (int i = 0; i < 7; i++) begin
      drive(1, addi(0, 0), 1, 0, '0, 0);
      if (i > 0) begin
        tests++; if (iss_vld !== 1'b1) begin fails++; $display("FAIL x0_issue%0d got %0b want 1", i, iss_vld); end
      end
      tick();
    end
    tests++; if (busy_o !== 32'd0) begin fails++; $display("FAIL x0_busy got %h want 0", busy_o); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      bit wb;
      logic [4:0] r;
      wb = $urandom_range(0, 2) == 0;
      r = 5'($urandom_range(0, 31));
      if (m_busy != 0 && $urandom_range(0, 3) != 0)
        for (int k = 0; k < 32; k++) if (m_busy[(int'(r) + k) % 32]) begin r = 5'((int'(r) + k) % 32); break; end
      drive($urandom_range(0, 3) != 0, rnd_instr(), $urandom_range(0, 3) != 0, wb, r, $urandom_range(0, 19) == 0);
      tests++; if (iss_vld !== exp_iss()) begin fails++; $display("FAIL rnd_iss_vld cycle %0d got %0b want %0b", n, iss_vld, exp_iss()); end
      tests++; if (idu_rdy !== exp_rdy()) begin fails++; $display("FAIL rnd_idu_rdy cycle %0d got %0b want %0b", n, idu_rdy, exp_rdy()); end
      tests++; if (busy_o !== m_busy) begin fails++; $display("FAIL rnd_busy cycle %0d got %h want %h", n, busy_o, m_busy); end
      if (m_hv) begin
        tests++; if (iss_data !== m_data || iss_addr !== m_addr) begin fails++; $display("FAIL rnd_hold cycle %0d got %h/%h want %h/%h", n, iss_addr, iss_data, m_addr, m_data); end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_independent();
    test_raw();
    test_backpressure();
    test_limit();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
